// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter (ALU vs. load/store) with a pending-write scoreboard for decode stalls.
// Define WB_RR_ARB_EN for round-robin arbitration; otherwise the ALU has fixed priority.
module regfile_wb_arbiter #(
  parameter int REG_NUM = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic [31:0] i_alu_data,
  output logic        o_alu_ready,
  input  logic        i_mem_valid,
  input  logic [4:0]  i_mem_rd,
  input  logic [31:0] i_mem_data,
  output logic        o_mem_ready,
  input  logic        i_issue_en,
  input  logic [4:0]  i_issue_rd,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic        o_stall,
  output logic        o_regs_w_en,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data
);

  // Handshake: a request transfers in any cycle where valid && ready; the requester
  // keeps valid/rd/data stable until then, and ready is never high without valid.
  logic               w_alu_grant;
  logic               w_mem_grant;
  logic               w_wr;
  logic [4:0]         w_grant_rd;
  logic [31:0]        w_grant_data;
  logic [REG_NUM-1:0] w_pend_next;
  logic [REG_NUM-1:0] r_pend;
  logic               r_regs_w_en;
  logic [4:0]         r_rd_addr;
  logic [31:0]        r_rd_data;

`ifdef WB_RR_ARB_EN
  logic w_both;
  logic r_prio;

  assign w_both      = i_alu_valid & i_mem_valid;
  assign w_alu_grant = ~i_rst & i_alu_valid & (~i_mem_valid | ~r_prio);
  assign w_mem_grant = ~i_rst & i_mem_valid & (~i_alu_valid | r_prio);

  // Pointer moves to the loser only when both sides competed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prio <= 1'b0;
    end else if (w_both) begin
      r_prio <= w_alu_grant;
    end
  end
`else
  assign w_alu_grant = ~i_rst & i_alu_valid;
  assign w_mem_grant = ~i_rst & i_mem_valid & ~i_alu_valid;
`endif

  assign w_grant_rd   = w_mem_grant ? i_mem_rd   : i_alu_rd;
  assign w_grant_data = w_mem_grant ? i_mem_data : i_alu_data;
  assign w_wr         = (w_alu_grant | w_mem_grant) & (w_grant_rd != 5'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_regs_w_en <= 1'b0;
      r_rd_addr   <= 5'd0;
      r_rd_data   <= 32'd0;
    end else begin
      r_regs_w_en <= w_wr;
      if (w_wr) begin
        r_rd_addr <= w_grant_rd;
        r_rd_data <= w_grant_data;
      end
    end
  end

  // Clear for the committing write first, so a same-cycle issue to that register stays pending.
  always_comb begin
    w_pend_next = r_pend;
    if (r_regs_w_en) begin
      w_pend_next[r_rd_addr] = 1'b0;
    end
    if (i_issue_en && (i_issue_rd != 5'd0)) begin
      w_pend_next[i_issue_rd] = 1'b1;
    end
    w_pend_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_next;
    end
  end

  assign o_alu_ready = w_alu_grant;
  assign o_mem_ready = w_mem_grant;
  assign o_stall     = r_pend[i_rs1_addr] | r_pend[i_rs2_addr];
  assign o_regs_w_en = r_regs_w_en;
  assign o_rd_addr   = r_rd_addr;
  assign o_rd_data   = r_rd_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed steps from the test plan, then randomized traffic
// checked against a rule-level model (pending-register array, grant rules, expected-write queue).
module tb_regfile_wb_arbiter;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, mem_valid = 1'b0, issue_en = 1'b0;
  logic [4:0]  alu_rd = '0, mem_rd = '0, issue_rd = '0, rs1_addr = '0, rs2_addr = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        alu_ready, mem_ready, stall, regs_w_en;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.REG_NUM(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data), .o_alu_ready(alu_ready),
    .i_mem_valid(mem_valid), .i_mem_rd(mem_rd), .i_mem_data(mem_data), .o_mem_ready(mem_ready),
    .i_issue_en(issue_en), .i_issue_rd(issue_rd), .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
    .o_stall(stall), .o_regs_w_en(regs_w_en), .o_rd_addr(rd_addr), .o_rd_data(rd_data)
  );

  // ---------------- reference model state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          pend_m[32];
  bit          prio_m = 1'b0;
  logic [37:0] exp_q[$];
  logic        cur_we = 1'b0;
  logic [4:0]  cur_addr = '0;
  logic [31:0] cur_data = '0;
  logic        acc_alu, acc_mem;
  logic        obs_alu_rdy, obs_mem_rdy, obs_stall;

  task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_stall();
    return pend_m[rs1_addr] | pend_m[rs2_addr];
  endfunction

  // One clock cycle with inputs already applied: check combinational outputs,
  // advance the model at the edge, then check the write port.
  task automatic cycle();
    logic [37:0] e;
    #1;
    acc_alu = 1'b0;
    acc_mem = 1'b0;
    if (!rst) begin
      if (alu_valid && !mem_valid)      acc_alu = 1'b1;
      else if (mem_valid && !alu_valid) acc_mem = 1'b1;
      else if (alu_valid && mem_valid) begin
`ifdef WB_RR_ARB_EN
        if (prio_m) acc_mem = 1'b1; else acc_alu = 1'b1;
`else
        acc_alu = 1'b1;
`endif
      end
    end
    obs_alu_rdy = alu_ready;
    obs_mem_rdy = mem_ready;
    obs_stall   = stall;
    chk("alu_ready", alu_ready, acc_alu);
    chk("mem_ready", mem_ready, acc_mem);
    chk("stall", stall, model_stall());
    @(posedge clk);
    if (rst) begin
      foreach (pend_m[i]) pend_m[i] = 1'b0;
      prio_m = 1'b0;
      exp_q.push_back({1'b0, 5'd0, 32'd0});
    end else begin
      if (cur_we) pend_m[cur_addr] = 1'b0;
      if (issue_en && issue_rd != 5'd0) pend_m[issue_rd] = 1'b1;
      if (alu_valid && mem_valid) prio_m = acc_alu;
      if (acc_alu && alu_rd != 5'd0)      exp_q.push_back({1'b1, alu_rd, alu_data});
      else if (acc_mem && mem_rd != 5'd0) exp_q.push_back({1'b1, mem_rd, mem_data});
      else                                exp_q.push_back({1'b0, cur_addr, cur_data});
    end
    #1;
    e = exp_q.pop_front();
    {cur_we, cur_addr, cur_data} = e;
    chk("regs_w_en", regs_w_en, cur_we);
    chk("rd_addr", rd_addr, cur_addr);
    chk("rd_data", rd_data, cur_data);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    foreach (pend_m[i]) pend_m[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset: requests offered during reset are refused and discarded
    rst = 1'b1; alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h1111;
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h2222;
    cycle();
    chk("rst_alu_ready", obs_alu_rdy, 1'b0);
    chk("rst_w_en", regs_w_en, 1'b0);
    rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    cycle();

    // ALU only, rd=5
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    cycle();
    chk("alu5_ready", obs_alu_rdy, 1'b1);
    chk("alu5_w_en", regs_w_en, 1'b1);
    chk("alu5_addr", rd_addr, 5'd5);
    chk("alu5_data", rd_data, 32'hDEADBEEF);
    alu_valid = 1'b0;
    cycle();
    chk("alu5_w_en_off", regs_w_en, 1'b0);

    // Contention for 4 cycles
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1A1A1A1;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hB2B2B2B2;
    for (int i = 0; i < 4; i++) begin
      cycle();
`ifdef WB_RR_ARB_EN
      chk("contend_alu", obs_alu_rdy, (i % 2) == 0);
      chk("contend_mem", obs_mem_rdy, (i % 2) == 1);
      chk("contend_addr", rd_addr, ((i % 2) == 0) ? 5'd1 : 5'd2);
`else
      chk("contend_alu", obs_alu_rdy, 1'b1);
      chk("contend_mem", obs_mem_rdy, 1'b0);
      chk("contend_addr", rd_addr, 5'd1);
`endif
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    cycle();

    // Issue rd=7, then MEM commits rd=7
    issue_en = 1'b1; issue_rd = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd0;
    cycle();
    chk("iss7_stall_I", obs_stall, 1'b0);
    issue_en = 1'b0;
    cycle();
    chk("iss7_stall_I1", obs_stall, 1'b1);
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77777777;
    cycle();
    chk("mem7_stall_K", obs_stall, 1'b1);
    mem_valid = 1'b0;
    cycle();
    chk("mem7_stall_K1", obs_stall, 1'b1);
    cycle();
    chk("mem7_stall_K2", obs_stall, 1'b0);

    // rd=0 writes and issues
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hCAFEF00D;
    cycle();
    chk("rd0_ready", obs_alu_rdy, 1'b1);
    chk("rd0_w_en", regs_w_en, 1'b0);
    alu_valid = 1'b0; issue_en = 1'b1; issue_rd = 5'd0; rs1_addr = 5'd0;
    cycle();
    issue_en = 1'b0;
    cycle();
    chk("rd0_stall", obs_stall, 1'b0);

    // Issue to rd=3 in the same cycle its older write commits
    issue_en = 1'b1; issue_rd = 5'd3; rs1_addr = 5'd0; rs2_addr = 5'd0;
    cycle();
    issue_en = 1'b0; alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33333333;
    cycle();
    alu_valid = 1'b0; issue_en = 1'b1; issue_rd = 5'd3;
    cycle();
    issue_en = 1'b0; rs2_addr = 5'd3;
    cycle();
    chk("same3_stall", obs_stall, 1'b1);
    cycle();
    chk("same3_stall_hold", obs_stall, 1'b1);
    rs2_addr = 5'd0;

    // Reset right after issuing rd=9
    issue_en = 1'b1; issue_rd = 5'd9;
    cycle();
    issue_en = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0; rs1_addr = 5'd9;
    cycle();
    chk("rst9_stall", obs_stall, 1'b0);

    // Randomized traffic
    alu_valid = 1'b0; mem_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!alu_valid || acc_alu) begin
        alu_valid = ($urandom_range(0, 3) != 0);
        alu_rd    = 5'($urandom_range(0, 31));
        alu_data  = $urandom;
      end
      if (!mem_valid || acc_mem) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        mem_rd    = 5'($urandom_range(0, 31));
        mem_data  = $urandom;
      end
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = 5'($urandom_range(0, 31));
      issue_rd = 5'($urandom_range(0, 31));
      issue_en = ($urandom_range(0, 1) == 1) && !model_stall();
      rst      = ($urandom_range(0, 99) == 0);
      cycle();
      if (rst) begin
        acc_alu = 1'b0;
        acc_mem = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port between two writeback requesters: the single-cycle ALU path and the multi-cycle load/store path. It also keeps a 32-entry pending-write scoreboard that the decode stage uses to stall reads of registers that still have a write in flight. The block sits between the execute/memory units and the register-file write port (`regs_w_en`, `rd_addr`, `rd_data`). It also feeds `stall` back to instruction issue.

## Interface
- `REG_NUM`, 32: number of architectural registers; scoreboard width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alu_valid`  in  1  ALU writeback request.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  32  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle.
- `mem_valid`  in  1  load-path writeback request.
- `mem_rd`  in  5  load destination register.
- `mem_data`  in  32  load result.
- `mem_ready`  out  1  load request accepted this cycle.
- `issue_en`  in  1  decode issues an instruction that will write `issue_rd`.
- `issue_rd`  in  5  destination of the issuing instruction.
- `rs1_addr`  in  5  source 1 of the instruction in decode.
- `rs2_addr`  in  5  source 2 of the instruction in decode.
- `stall`  out  1  decode must hold; a source has a pending write.
- `regs_w_en`  out  1  register-file write enable (registered).
- `rd_addr`  out  5  register-file write address (registered).
- `rd_data`  out  32  register-file write data (registered).

## Operation
**Arbitration**
- Each cycle, at most one request is granted.
- `*_ready` is combinational from the `*_valid` inputs and the priority pointer.
- A request completes when valid && ready in the same cycle.
- A requester holds valid, rd and data stable until it is accepted.
- Only one requester valid: it is granted.
- Both requesters valid: the one the pointer selects is granted.
  - Pointer `prio` (0 = ALU, 1 = MEM) moves to the non-granted side after every contested grant.
  - `prio` is not updated on uncontested grants.
- `*_ready` is 0 whenever the corresponding `*_valid` is 0.

**Write port**
- On a grant with rd ≠ 0, the next cycle drives `regs_w_en`=1, `rd_addr`=rd, `rd_data`=data.
- With no grant, the next cycle drives `regs_w_en`=0, and `rd_addr`/`rd_data` hold their last values.
- A granted request with rd = 0 is accepted (ready=1) but produces `regs_w_en`=0 and no scoreboard effect.

**Scoreboard**
- `pend[REG_NUM-1:0]`; `pend[0]` is constant 0.
- Set: `issue_en` && `issue_rd` ≠ 0 sets `pend[issue_rd]` at the clock edge.
- Clear: in any cycle with `regs_w_en`=1, `pend[rd_addr]` is cleared at the end of that cycle.
- Same register set and cleared in the same cycle: set wins. The commit belongs to the older writer; the newly issued writer remains pending.
- `stall` = `pend[rs1_addr]` | `pend[rs2_addr]`, combinational.
- `stall` does not gate `issue_en` internally; decode must not assert `issue_en` while `stall`=1.

**Reset**
- `rst`=1 at a rising edge forces:
  - `regs_w_en`=0, `rd_addr`=0, `rd_data`=0;
  - `pend`=0, so `stall`=0;
  - `prio`=0 (ALU).
- A request accepted in the reset cycle is discarded.
- `alu_ready`/`mem_ready` are 0 while `rst`=1.

## Timing
- Accept in cycle N → write port active in N+1 → register file holds the value from N+2.
- Scoreboard clear happens at the end of N+1, so `stall` drops in N+2 for a reader of that register. No bypass path.
- Issue in cycle I → `stall` for a dependent reader visible from cycle I+1.
- Throughput: one write per cycle; a continuously contested port alternates ALU/MEM.
- No multi-cycle state beyond the `prio`, `pend` and output registers.

## Configuration
- `WB_RR_ARB_EN` defined: round-robin arbitration as above.
- `WB_RR_ARB_EN` undefined: fixed priority.
  - ALU always wins contention; `prio` is removed.
  - MEM is granted only in cycles with `alu_valid`=0; MEM starvation is the caller's responsibility.

## Test plan
- Reset → `regs_w_en`=0, `rd_addr`=0, `rd_data`=0, `stall`=0, both readies 0 while `rst`=1.
- ALU only, rd=5, data=0xDEADBEEF in cycle N → `alu_ready`=1 in N; N+1 `regs_w_en`=1, `rd_addr`=5, `rd_data`=0xDEADBEEF; N+2 `regs_w_en`=0.
- Both valid for 4 cycles (ALU rd=1, MEM rd=2, requests reissued on accept), `WB_RR_ARB_EN` defined → grants ALU, MEM, ALU, MEM. Undefined → ALU four times, `mem_ready`=0 throughout.
- Issue rd=7 in cycle I, decode `rs1_addr`=7 → `stall`=1 from I+1. Accept MEM rd=7 in cycle K → `stall`=1 through K+1, `stall`=0 in K+2.
- Write to rd=0 granted → `alu_ready`=1, `regs_w_en` stays 0; `issue_rd`=0 → `stall` never asserts for `rs1_addr`=0.
- `issue_en` rd=3 in the same cycle as `regs_w_en`=1 with `rd_addr`=3 → `pend[3]` remains 1, and `stall` stays 1 for `rs2_addr`=3.
- `rst` asserted the cycle after issuing rd=9 → `pend[9]`=0 and `stall`=0 after reset.
